ff_bank: RTL and testbench
==========================

Name: ff_bank

Overview:
- Parametrised bank of WIDTH clocked flip-flop cells. One run-time mode input selects SR, JK, D or T behaviour for all cells.
- Successor to the single-bit SR flip-flop. Differences from it:
  - defined handling of the SR 1/1 input, with no high-impedance or X output;
  - clock enable;
  - programmable reset value;
  - sticky per-bit invalid-input flags and a saturating invalid-event counter.
- Used as the generic state-holding element in lab datapaths and counters.

Parameters:
- WIDTH, 8: number of flip-flop cells (1..64).
- RESET_VAL, 0: WIDTH-bit value loaded into q on reset.
- SR11_POLICY, 0: SR-mode response to S=R=1. 0 = hold q, 1 = force q=0, 2 = force q=1. Value 3 is illegal and treated as 0.
- CNT_W, 4: width of the invalid-event counter (1..16).

Ports:
- clk  in  1  rising-edge clock.
- cl  in  1  asynchronous reset, active-low. Asserting it resets state immediately; state is released on the next clk edge after deassertion.
- en  in  1  clock enable; 0 = all cells hold, no flags or count updates.
- mode  in  2  00 = SR, 01 = JK, 10 = D, 11 = T. Shared by all cells.
- a  in  WIDTH  per-cell first input: S (SR), J (JK), D (D), T (T).
- b  in  WIDTH  per-cell second input: R (SR), K (JK). Ignored in D and T modes.
- inv_clr  in  1  synchronous clear of inv and inv_cnt.
- q  out  WIDTH  cell state.
- nq  out  WIDTH  bitwise complement of q, always.
- inv  out  WIDTH  sticky per-cell flag: SR 1/1 was applied with en=1.
- inv_cnt  out  CNT_W  saturating count of enabled cycles in which any cell saw SR 1/1.

Behaviour:
- Reset (cl=0, asynchronous):
  - q = RESET_VAL, nq = ~RESET_VAL;
  - inv = 0, inv_cnt = 0.
  - Reset mid-operation overrides en, mode and inv_clr immediately.
- Latency: inputs sampled on the rising clk edge; q, nq, inv and inv_cnt update on that edge (one cycle). No combinational path from inputs to outputs.
- en=0: q, nq, inv and inv_cnt hold. inv_clr is still honoured.
- Per-cell next state when en=1:
  - SR: a/b = 10 -> q=1; 01 -> q=0; 00 -> hold; 11 -> apply SR11_POLICY and set inv[i].
  - JK: 10 -> q=1; 01 -> q=0; 00 -> hold; 11 -> q=~q. Never flags.
  - D: q = a[i]; b ignored.
  - T: a[i]=1 -> q=~q; a[i]=0 -> hold; b ignored.
- Outputs never go Z or X: nq is derived from q and is never independently driven.
- A mode change takes effect on the same edge it is sampled; there is no pipeline drain.
- inv_cnt:
  - increments by 1, not by the number of offending cells, on each enabled SR-mode edge where any a[i]&b[i]=1;
  - saturates at 2^CNT_W-1 and does not wrap.
- inv_clr on the same edge as a new invalid event: new event wins. inv = that edge's offending mask; inv_cnt = 1.
- inv_clr with no event: inv = 0, inv_cnt = 0.
- WIDTH=1 must be legal and behave as a single cell.

Decomposition:
- Shared package ff_pkg:
  - mode encodings MODE_SR, MODE_JK, MODE_D, MODE_T;
  - policy constants SR11_HOLD, SR11_CLR, SR11_SET.
- Sub-module ff_cell: one bit with mode, policy and en inputs. Outputs q and an invalid strobe.
- ff_bank instantiates WIDTH ff_cell cells via generate. The bank owns the inv register, the OR-reduction of strobes, and the saturating counter.

Test Plan:
1. Reset and SR mode:
   - Stimulus: RESET_VAL=8'hA5, cl pulsed low mid-cycle.
   - Response: q=A5, nq=5A immediately.
   - Then SR, a=0F, b=F0 -> q=0F next edge.
2. SR 1/1 hold policy and counter:
   - Stimulus: SR11_POLICY=0, q=0F, a=b=03, three enabled edges.
   - Response: q=0F, inv=03, inv_cnt=3. nq=F0, never X/Z.
3. Counter saturation and clear collision:
   - Stimulus: CNT_W=2, six invalid edges.
   - Response: inv_cnt=3 (held).
   - Then inv_clr=1 with a=b=80 -> inv=80, inv_cnt=1.
4. JK and T toggle:
   - JK, q=00, a=b=FF -> q=FF, then 00; inv unchanged.
   - T, a=01 for 4 edges -> q[0] toggles 4 times.
5. Enable and D mode:
   - D, a=3C, en=0 -> q unchanged.
   - en=1 -> q=3C next edge.
   - Mode switch to SR with a=b=00 on the next edge -> q holds 3C.
6. Policy variants:
   - SR11_POLICY=1 and 2, a=b=FF -> q=00 and q=FF respectively.
   - inv=FF in both cases.

Source files
------------

// File: rtl/ff_pkg.sv
// Shared encodings for the configurable flip-flop bank.
package ff_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [1:0] SR11_HOLD = 2'd0;
  localparam logic [1:0] SR11_CLR  = 2'd1;
  localparam logic [1:0] SR11_SET  = 2'd2;

  // Any unrecognised policy value behaves as hold.
  function automatic logic [1:0] legal_policy(input int p);
    return (p == 1) ? SR11_CLR : (p == 2) ? SR11_SET : SR11_HOLD;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// Single configurable SR/JK/D/T flip-flop cell with an SR 1/1 strobe.
module ff_cell
  import ff_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       cl,
  input  logic       en,
  input  mode_e      mode,
  input  logic [1:0] policy,
  input  logic       a,
  input  logic       b,
  output logic       q,
  output logic       inv_stb
);

  logic q_nxt;

  always_comb begin
    q_nxt   = q;
    inv_stb = 1'b0;
    if (en) begin
      case (mode)
        MODE_SR: begin
          case ({a, b})
            2'b10: q_nxt = 1'b1;
            2'b01: q_nxt = 1'b0;
            2'b11: begin
              inv_stb = 1'b1;
              case (policy)
                SR11_CLR: q_nxt = 1'b0;
                SR11_SET: q_nxt = 1'b1;
                default:  q_nxt = q;
              endcase
            end
            default: q_nxt = q;
          endcase
        end
        MODE_JK: begin
          case ({a, b})
            2'b10:   q_nxt = 1'b1;
            2'b01:   q_nxt = 1'b0;
            2'b11:   q_nxt = ~q;
            default: q_nxt = q;
          endcase
        end
        MODE_D:  q_nxt = a;
        MODE_T:  q_nxt = a ? ~q : q;
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge cl) begin
    if (!cl) q <= RESET_BIT;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with sticky SR 1/1 flags
// and a saturating invalid-event counter.
module ff_bank
  import ff_pkg::*;
#(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL   = '0,
  parameter int                 SR11_POLICY = 0,
  parameter int                 CNT_W       = 4
) (
  input  logic             clk,
  input  logic             cl,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inv_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic [WIDTH-1:0] inv,
  output logic [CNT_W-1:0] inv_cnt
);

  localparam logic [1:0]       POLICY  = legal_policy(SR11_POLICY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] stb;
  logic             any_inv;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(.RESET_BIT(RESET_VAL[i])) u_cell (
      .clk     (clk),
      .cl      (cl),
      .en      (en),
      .mode    (mode_e'(mode)),
      .policy  (POLICY),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q[i]),
      .inv_stb (stb[i])
    );
  end

  assign nq      = ~q;
  assign any_inv = |stb;

  // A fresh event beats a simultaneous clear: flags restart from this edge.
  always_ff @(posedge clk or negedge cl) begin
    if (!cl) begin
      inv     <= '0;
      inv_cnt <= '0;
    end else if (any_inv) begin
      if (inv_clr) begin
        inv     <= stb;
        inv_cnt <= CNT_W'(1);
      end else begin
        inv <= inv | stb;
        if (inv_cnt != CNT_MAX) inv_cnt <= inv_cnt + 1'b1;
      end
    end else if (inv_clr) begin
      inv     <= '0;
      inv_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ff_bank.sv
// Randomised check of four ff_bank configurations against a per-bit behavioural model.
module tb_ff_bank;

  logic       clk = 1'b0;
  logic       cl, en, inv_clr;
  logic [1:0] mode;
  logic [7:0] a, b;

  logic [7:0] q0, nq0, inv0; logic [3:0] cnt0;
  logic [7:0] q1, nq1, inv1; logic [1:0] cnt1;
  logic [7:0] q2, nq2, inv2; logic [2:0] cnt2;
  logic [0:0] q3, nq3, inv3; logic [0:0] cnt3;

  always #5 clk = ~clk;

  ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR11_POLICY(0), .CNT_W(4)) u0 (
    .clk(clk), .cl(cl), .en(en), .mode(mode), .a(a), .b(b), .inv_clr(inv_clr),
    .q(q0), .nq(nq0), .inv(inv0), .inv_cnt(cnt0));
  ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR11_POLICY(1), .CNT_W(2)) u1 (
    .clk(clk), .cl(cl), .en(en), .mode(mode), .a(a), .b(b), .inv_clr(inv_clr),
    .q(q1), .nq(nq1), .inv(inv1), .inv_cnt(cnt1));
  ff_bank #(.WIDTH(8), .RESET_VAL(8'hFF), .SR11_POLICY(2), .CNT_W(3)) u2 (
    .clk(clk), .cl(cl), .en(en), .mode(mode), .a(a), .b(b), .inv_clr(inv_clr),
    .q(q2), .nq(nq2), .inv(inv2), .inv_cnt(cnt2));
  ff_bank #(.WIDTH(1), .RESET_VAL(1'b1), .SR11_POLICY(3), .CNT_W(1)) u3 (
    .clk(clk), .cl(cl), .en(en), .mode(mode), .a(a[0:0]), .b(b[0:0]), .inv_clr(inv_clr),
    .q(q3), .nq(nq3), .inv(inv3), .inv_cnt(cnt3));

  localparam int          MW[4]    = '{8, 8, 8, 1};
  localparam logic [63:0] MRV[4]   = '{64'hA5, 64'h00, 64'hFF, 64'h1};
  localparam int          MPOL[4]  = '{0, 1, 2, 3};
  localparam int          MCMAX[4] = '{15, 3, 7, 1};

  logic [63:0] mq[4], minv[4];
  int          mcnt[4];
  logic [63:0] nx, mask;

  logic [63:0] dq[4], dnq[4], dinv[4], dcnt[4];
  assign dq[0] = {56'b0, q0};  assign dnq[0] = {56'b0, nq0};
  assign dq[1] = {56'b0, q1};  assign dnq[1] = {56'b0, nq1};
  assign dq[2] = {56'b0, q2};  assign dnq[2] = {56'b0, nq2};
  assign dq[3] = {63'b0, q3};  assign dnq[3] = {63'b0, nq3};
  assign dinv[0] = {56'b0, inv0}; assign dcnt[0] = {60'b0, cnt0};
  assign dinv[1] = {56'b0, inv1}; assign dcnt[1] = {62'b0, cnt1};
  assign dinv[2] = {56'b0, inv2}; assign dcnt[2] = {61'b0, cnt2};
  assign dinv[3] = {63'b0, inv3}; assign dcnt[3] = {63'b0, cnt3};

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] wmask(input int k);
    return (64'd1 << MW[k]) - 64'd1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k] = MRV[k]; minv[k] = '0; mcnt[k] = 0;
    end
  endtask

  always @(negedge cl) model_reset();

  // Reference: per-bit truth tables from the mode rules, then flag/counter bookkeeping.
  always @(posedge clk) begin
    if (!cl) model_reset();
    else begin
      for (int k = 0; k < 4; k++) begin
        nx = mq[k];
        mask = '0;
        if (en) begin
          for (int i = 0; i < MW[k]; i++) begin
            case (mode)
              2'd0: if (a[i] && b[i]) begin
                      mask[i] = 1'b1;
                      if (MPOL[k] == 1) nx[i] = 1'b0;
                      else if (MPOL[k] == 2) nx[i] = 1'b1;
                    end else if (a[i]) nx[i] = 1'b1;
                    else if (b[i]) nx[i] = 1'b0;
              2'd1: if (a[i] && b[i]) nx[i] = ~nx[i];
                    else if (a[i]) nx[i] = 1'b1;
                    else if (b[i]) nx[i] = 1'b0;
              2'd2: nx[i] = a[i];
              default: if (a[i]) nx[i] = ~nx[i];
            endcase
          end
        end
        mq[k] = nx;
        if (mask != 0) begin
          if (inv_clr) begin minv[k] = mask; mcnt[k] = 1; end
          else begin
            minv[k] = minv[k] | mask;
            if (mcnt[k] < MCMAX[k]) mcnt[k] = mcnt[k] + 1;
          end
        end else if (inv_clr) begin
          minv[k] = '0; mcnt[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("q%0d", k), dq[k], mq[k]);
        chk($sformatf("nq%0d", k), dnq[k], ~mq[k] & wmask(k));
        chk($sformatf("inv%0d", k), dinv[k], minv[k]);
        chk($sformatf("cnt%0d", k), dcnt[k], 64'(mcnt[k]));
      end
    end
  end

  task automatic step(input logic e, input logic [1:0] m, input logic [7:0] aa,
                      input logic [7:0] bb, input logic c);
    en = e; mode = m; a = aa; b = bb; inv_clr = c;
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    cl = 1'b0; en = 1'b0; mode = 2'd0; a = '0; b = '0; inv_clr = 1'b0;
    model_reset();
    @(negedge clk);
    chk_on = 1'b1;
    #2;
    chk("rst_q", dq[0], 64'hA5);
    chk("rst_nq", dnq[0], 64'h5A);
    chk("rst_cnt", dcnt[0], 64'h0);
    cl = 1'b1;

    // mid-cycle async reset
    step(1'b1, 2'd2, 8'hFF, 8'h00, 1'b0);
    chk("d_ff", dq[0], 64'hFF);
    @(posedge clk); #2; cl = 1'b0; #1;
    chk("async_q", dq[0], 64'hA5);
    chk("async_nq", dnq[0], 64'h5A);
    chk("async_mdl", mq[0], 64'hA5);
    @(negedge clk); #2; cl = 1'b1;

    step(1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0);
    chk("sr_q", dq[0], 64'h0F);
    chk("sr_mdl", mq[0], 64'h0F);

    repeat (3) step(1'b1, 2'd0, 8'h03, 8'h03, 1'b0);
    chk("hold_q", dq[0], 64'h0F);
    chk("hold_nq", dnq[0], 64'hF0);
    chk("hold_inv", dinv[0], 64'h03);
    chk("hold_cnt", dcnt[0], 64'd3);
    chk("clr_pol_q", dq[1], 64'h0C);

    repeat (3) step(1'b1, 2'd0, 8'h03, 8'h03, 1'b0);
    chk("sat_cnt", dcnt[1], 64'd3);
    chk("cnt6", dcnt[0], 64'd6);
    chk("sat_mdl", 64'(mcnt[1]), 64'd3);
    step(1'b1, 2'd0, 8'h80, 8'h80, 1'b1);
    chk("coll_inv", dinv[1], 64'h80);
    chk("coll_cnt", dcnt[1], 64'd1);
    chk("coll_cnt0", dcnt[0], 64'd1);

    step(1'b1, 2'd2, 8'h00, 8'h00, 1'b0);
    step(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0);
    chk("jk_ff", dq[0], 64'hFF);
    chk("jk_inv", dinv[0], 64'h80);
    step(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0);
    chk("jk_00", dq[0], 64'h00);
    for (int t = 0; t < 4; t++) begin
      step(1'b1, 2'd3, 8'h01, 8'hFF, 1'b0);
      chk("t_tog", dq[0], (t % 2 == 0) ? 64'h01 : 64'h00);
    end

    step(1'b0, 2'd2, 8'h3C, 8'h00, 1'b0);
    chk("en0_q", dq[0], 64'h00);
    step(1'b1, 2'd2, 8'h3C, 8'h00, 1'b0);
    chk("d_3c", dq[0], 64'h3C);
    step(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
    chk("sr_hold_3c", dq[0], 64'h3C);

    step(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0);
    chk("pol1_q", dq[1], 64'h00);
    chk("pol2_q", dq[2], 64'hFF);
    chk("pol1_inv", dinv[1], 64'hFF);
    chk("pol2_inv", dinv[2], 64'hFF);

    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      a = 8'($urandom); b = 8'($urandom);
      inv_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk); #2; cl = 1'b0;
        @(negedge clk); #2; cl = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
        #2;
      end
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
